// File: rtl/fb_pixel_writer_pkg.sv
// Shared frame-buffer constants: op codes, writer states, geometry.
// Geometry matches the VGA scan-out block's row/bit addressing.
package fb_pkg;

  typedef enum logic [1:0] {
    FB_OP_SET  = 2'b00,
    FB_OP_CLR  = 2'b01,
    FB_OP_TOG  = 2'b10,
    FB_OP_FILL = 2'b11
  } fb_op_e;

  typedef enum logic [1:0] {
    FB_ST_IDLE = 2'b00,
    FB_ST_RD   = 2'b01,
    FB_ST_WR   = 2'b10,
    FB_ST_FILL = 2'b11
  } fb_state_e;

  localparam int FB_ROWS      = 32;
  localparam int FB_COLS      = 32;
  localparam int FB_ROW_BYTES = 4;

  function automatic logic [31:0] fb_row_addr(
    input logic [31:0] base,
    input logic [4:0]  row
  );
    return base + 32'(row) * 32'(FB_ROW_BYTES);
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Command and frame-memory bus of the pixel writer.
// Also carries the display cursor (point/mark) outputs.
interface fb_pixel_writer_if;
  import fb_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  fb_op_e      cmd_op;
  logic [4:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [31:0] cmd_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] point_out;
  logic        mark;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y,
    output cmd_data, mem_rdata,
    input  cmd_ready, mem_addr, mem_we,
    input  mem_wdata, point_out, mark
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y,
    input  cmd_data, mem_rdata,
    output cmd_ready, mem_addr, mem_we,
    output mem_wdata, point_out, mark
  );

endinterface

// File: rtl/fb_pixel_writer.sv
// Read-modify-write pixel agent and FILL engine for the 32x32 frame memory.
// Cursor outputs are built only with FB_PIXEL_WRITER_CURSOR_EN defined.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  fb_pixel_writer_if.slave bus
);

  localparam logic [31:0] BASE_W   = {BASE_ADDR[31:2], 2'b00};
  localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);
  localparam logic [4:0]  ROW_LAST = 5'(FB_ROWS - 1);

  fb_state_e   state_q, state_d;
  fb_op_e      op_q;
  logic [4:0]  x_q, y_q;
  logic [31:0] data_q;
  logic [1:0]  lat_q, lat_d;
  logic [4:0]  row_q, row_d;
  logic        accept;
  logic [31:0] mask;
  logic [31:0] pix_word;

  assign accept = bus.cmd_valid && (state_q == FB_ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FB_ST_IDLE;
      lat_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= FB_OP_SET;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= bus.cmd_op;
      x_q    <= bus.cmd_x;
      y_q    <= bus.cmd_y;
      data_q <= bus.cmd_data;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    row_d   = row_q;
    unique case (state_q)
      FB_ST_IDLE: begin
        if (accept) begin
          state_d = (bus.cmd_op == FB_OP_FILL) ? FB_ST_FILL : FB_ST_RD;
          lat_d   = LAT_INIT;
          row_d   = '0;
        end
      end
      FB_ST_RD: begin
        if (lat_q == 2'd0) state_d = FB_ST_WR;
        else               lat_d   = lat_q - 2'd1;
      end
      FB_ST_WR: state_d = FB_ST_IDLE;
      FB_ST_FILL: begin
        // Stop on the last row so the counter never wraps into a 33rd write.
        if (row_q == ROW_LAST) state_d = FB_ST_IDLE;
        else                   row_d   = row_q + 5'd1;
      end
      default: state_d = FB_ST_IDLE;
    endcase
  end

  assign mask = 32'd1 << x_q;

  always_comb begin
    pix_word = bus.mem_rdata;
    unique case (op_q)
      FB_OP_SET: pix_word = bus.mem_rdata | mask;
      FB_OP_CLR: pix_word = bus.mem_rdata & ~mask;
      FB_OP_TOG: pix_word = bus.mem_rdata ^ mask;
      default:   pix_word = bus.mem_rdata;
    endcase
  end

  always_comb begin
    bus.mem_wdata = '0;
    if (state_q == FB_ST_WR)   bus.mem_wdata = pix_word;
    if (state_q == FB_ST_FILL) bus.mem_wdata = data_q;
  end

  assign bus.cmd_ready = (state_q == FB_ST_IDLE);
  assign bus.mem_we    = (state_q == FB_ST_WR) || (state_q == FB_ST_FILL);
  assign bus.mem_addr  = fb_row_addr(
    BASE_W, (state_q == FB_ST_FILL) ? row_q : y_q);

`ifdef FB_PIXEL_WRITER_CURSOR_EN
  logic [31:0] point_q;
  logic [31:0] point_new;

  assign point_new = {22'd0, y_q, x_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        point_q <= '0;
    else if (state_q == FB_ST_WR)   point_q <= point_new;
  end

  assign bus.point_out = (state_q == FB_ST_WR) ? point_new : point_q;
  assign bus.mark      = (state_q == FB_ST_WR);
`else
  assign bus.point_out = '0;
  assign bus.mark      = 1'b0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: RD_LAT=1 and RD_LAT=3 instances
// sharing clk/rst, each backed by a small frame memory model.
module tb_fb_pixel_writer;
  import fb_pkg::*;

`ifdef FB_PIXEL_WRITER_CURSOR_EN
  localparam logic CUR = 1'b1;
`else
  localparam logic CUR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_pixel_writer_if ifa ();
  fb_pixel_writer_if ifb ();

  fb_pixel_writer #(.RD_LAT(1), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));

  fb_pixel_writer #(.RD_LAT(3), .BASE_ADDR(32'h0000_0103)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic        ld;
  logic [4:0]  ld_idx;
  logic [31:0] ld_val_a, ld_val_b;
  logic [31:0] rb1, rb2;
  int          we_a = 0, mark_a = 0, we_b = 0;

  always_ff @(posedge clk) begin
    if (ld) mem_a[ld_idx] <= ld_val_a;
    else if (ifa.mem_we) mem_a[ifa.mem_addr[6:2]] <= ifa.mem_wdata;
    ifa.mem_rdata <= mem_a[ifa.mem_addr[6:2]];
    if (ifa.mem_we) we_a <= we_a + 1;
    if (ifa.mark)   mark_a <= mark_a + 1;
  end

  always_ff @(posedge clk) begin
    if (ld) mem_b[ld_idx] <= ld_val_b;
    else if (ifb.mem_we) mem_b[ifb.mem_addr[6:2]] <= ifb.mem_wdata;
    rb1 <= mem_b[ifb.mem_addr[6:2]];
    rb2 <= rb1;
    ifb.mem_rdata <= rb2;
    if (ifb.mem_we) we_b <= we_b + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix_a(input fb_op_e op, input logic [4:0] x,
                       input logic [4:0] y);
    int n;
    ifa.cmd_valid = 1'b1;
    ifa.cmd_op    = op;
    ifa.cmd_x     = x;
    ifa.cmd_y     = y;
    tick();
    ifa.cmd_valid = 1'b0;
    n = 0;
    while (!ifa.cmd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("pix_a_done", 32'(ifa.cmd_ready), 32'd1);
  endtask

  int m0, w0, n;

  initial begin
    rst = 1'b1;
    ld = 1'b0; ld_idx = '0; ld_val_a = '0; ld_val_b = '0;
    ifa.cmd_valid = 1'b0; ifa.cmd_op = FB_OP_SET;
    ifa.cmd_x = '0; ifa.cmd_y = '0; ifa.cmd_data = '0;
    ifb.cmd_valid = 1'b0; ifb.cmd_op = FB_OP_SET;
    ifb.cmd_x = '0; ifb.cmd_y = '0; ifb.cmd_data = '0;
    tick();

    chk("rst_ready", 32'(ifa.cmd_ready), 32'd1);
    chk("rst_we", 32'(ifa.mem_we), 32'd0);
    chk("rst_addr", ifa.mem_addr, 32'h0);
    chk("rst_wdata", ifa.mem_wdata, 32'h0);
    chk("rst_point", ifa.point_out, 32'h0);
    chk("rst_mark", 32'(ifa.mark), 32'd0);
    chk("rst_addr_b", ifb.mem_addr, 32'h0000_0100);

    ld = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ld_idx   = 5'(i);
      ld_val_a = (i == 31) ? 32'hFFFF_FFFF :
                 (i == 7)  ? 32'h1234_5670 : 32'h0;
      ld_val_b = 32'h0;
      tick();
    end
    ld = 1'b0;
    rst = 1'b0;
    tick();

    // SET x=3 y=5, RD_LAT=1
    ifa.cmd_valid = 1'b1; ifa.cmd_op = FB_OP_SET;
    ifa.cmd_x = 5'd3; ifa.cmd_y = 5'd5; ifa.cmd_data = 32'hDEAD_BEEF;
    tick();
    ifa.cmd_valid = 1'b0;
    chk("set_rd_ready", 32'(ifa.cmd_ready), 32'd0);
    chk("set_rd_we", 32'(ifa.mem_we), 32'd0);
    chk("set_rd_addr", ifa.mem_addr, 32'h14);
    tick();
    chk("set_wr_we", 32'(ifa.mem_we), 32'd1);
    chk("set_wr_addr", ifa.mem_addr, 32'h14);
    chk("set_wr_data", ifa.mem_wdata, 32'h0000_0008);
    chk("set_wr_mark", 32'(ifa.mark), 32'(CUR));
    chk("set_wr_point", ifa.point_out, CUR ? 32'h0000_00A3 : 32'h0);
    tick();
    chk("set_idle_ready", 32'(ifa.cmd_ready), 32'd1);
    chk("set_idle_we", 32'(ifa.mem_we), 32'd0);
    chk("set_idle_mark", 32'(ifa.mark), 32'd0);
    chk("set_idle_point", ifa.point_out, CUR ? 32'h0000_00A3 : 32'h0);
    chk("set_mem", mem_a[5], 32'h0000_0008);

    // CLR x=31 y=31 on an all-ones row
    ifa.cmd_valid = 1'b1; ifa.cmd_op = FB_OP_CLR;
    ifa.cmd_x = 5'd31; ifa.cmd_y = 5'd31;
    tick();
    ifa.cmd_valid = 1'b0;
    chk("clr_rd_addr", ifa.mem_addr, 32'h7C);
    tick();
    chk("clr_wr_we", 32'(ifa.mem_we), 32'd1);
    chk("clr_wr_addr", ifa.mem_addr, 32'h7C);
    chk("clr_wr_data", ifa.mem_wdata, 32'h7FFF_FFFF);
    chk("clr_wr_point", ifa.point_out, CUR ? 32'h0000_03FF : 32'h0);
    tick();
    chk("clr_ready", 32'(ifa.cmd_ready), 32'd1);
    chk("clr_mem", mem_a[31], 32'h7FFF_FFFF);

    // TOG x=0 twice, back to back
    m0 = mark_a;
    pix_a(FB_OP_TOG, 5'd0, 5'd7);
    chk("tog1_mem", mem_a[7], 32'h1234_5671);
    pix_a(FB_OP_TOG, 5'd0, 5'd7);
    chk("tog2_mem", mem_a[7], 32'h1234_5670);
    chk("tog_marks", 32'(mark_a - m0), CUR ? 32'd2 : 32'd0);

    // FILL A5A5A5A5
    w0 = we_a; m0 = mark_a;
    ifa.cmd_valid = 1'b1; ifa.cmd_op = FB_OP_FILL;
    ifa.cmd_data = 32'hA5A5_A5A5;
    tick();
    ifa.cmd_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("fill_rdy_we", {30'd0, ifa.cmd_ready, ifa.mem_we}, 32'd1);
      chk("fill_addr", ifa.mem_addr, 32'(i * 4));
      chk("fill_data", ifa.mem_wdata, 32'hA5A5_A5A5);
      chk("fill_mark", 32'(ifa.mark), 32'd0);
      tick();
    end
    chk("fill_end_ready", 32'(ifa.cmd_ready), 32'd1);
    chk("fill_end_we", 32'(ifa.mem_we), 32'd0);
    chk("fill_writes", 32'(we_a - w0), 32'd32);
    chk("fill_marks", 32'(mark_a - m0), 32'd0);
    for (int i = 0; i < 32; i++)
      chk("fill_mem", mem_a[5'(i)], 32'hA5A5_A5A5);

    // FILL interrupted by reset during its 10th write
    ifa.cmd_valid = 1'b1; ifa.cmd_op = FB_OP_FILL;
    ifa.cmd_data = 32'h0F0F_0F0F;
    tick();
    ifa.cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_pre_addr", ifa.mem_addr, 32'h24);
    chk("abort_pre_we", 32'(ifa.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(ifa.mem_we), 32'd0);
    chk("abort_ready", 32'(ifa.cmd_ready), 32'd1);
    chk("abort_addr", ifa.mem_addr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_ready", 32'(ifa.cmd_ready), 32'd1);
    for (int i = 0; i < 9; i++)
      chk("abort_lo_rows", mem_a[5'(i)], 32'h0F0F_0F0F);
    for (int i = 10; i < 32; i++)
      chk("abort_hi_rows", mem_a[5'(i)], 32'hA5A5_A5A5);
    pix_a(FB_OP_SET, 5'd4, 5'd10);
    chk("post_abort_set", mem_a[10], 32'hA5A5_A5B5);

    // RD_LAT=3, cmd_valid held while busy
    ifb.cmd_valid = 1'b1; ifb.cmd_op = FB_OP_SET;
    ifb.cmd_x = 5'd1; ifb.cmd_y = 5'd2;
    tick();
    ifb.cmd_op = FB_OP_TOG; ifb.cmd_x = 5'd6; ifb.cmd_y = 5'd3;
    for (int k = 0; k < 3; k++) begin
      chk("b_rd_ready", 32'(ifb.cmd_ready), 32'd0);
      chk("b_rd_we", 32'(ifb.mem_we), 32'd0);
      chk("b_rd_addr", ifb.mem_addr, 32'h108);
      tick();
    end
    chk("b_wr_we", 32'(ifb.mem_we), 32'd1);
    chk("b_wr_addr", ifb.mem_addr, 32'h108);
    chk("b_wr_data", ifb.mem_wdata, 32'h0000_0002);
    chk("b_wr_point", ifb.point_out, CUR ? 32'h0000_0041 : 32'h0);
    tick();
    chk("b_idle_ready", 32'(ifb.cmd_ready), 32'd1);
    tick();
    ifb.cmd_valid = 1'b0;
    chk("b_held_ready", 32'(ifb.cmd_ready), 32'd0);
    chk("b_held_addr", ifb.mem_addr, 32'h10C);
    n = 0;
    while (!ifb.cmd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("b_held_done", 32'(ifb.cmd_ready), 32'd1);
    chk("b_mem_row2", mem_b[2], 32'h0000_0002);
    chk("b_mem_row3", mem_b[3], 32'h0000_0040);
    chk("b_writes", 32'(we_b), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
